// File: rtl/fwid_reader_pkg.sv
// Shared quabo firmware-ID definitions: reader state encoding, ID word width and default ROM latency.
package fwid_reader_pkg;

  localparam int FWID_W          = 64;
  localparam int ROM_LAT_DEFAULT = 0;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/fwid_shift_capture.sv
// LSB-addressed capture register: writes one bit at idx per capture and copies the word to q on load.
// With FWID_READER_VERIFY_EN the merged word is exported for the two-pass compare.
module fwid_shift_capture
  import fwid_reader_pkg::*;
#(
  parameter int W  = FWID_W,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          capture,
  input  logic [AW-1:0] idx,
  input  logic          bit_in,
  input  logic          load,
`ifdef FWID_READER_VERIFY_EN
  output logic [W-1:0]  word,
`endif
  output logic [W-1:0]  q
);

  logic [W-1:0] shreg;
  logic [W-1:0] merged;

  // A load on the same edge as the final capture must include that last bit.
  always_comb begin
    merged = shreg;
    if (capture) merged[idx] = bit_in;
  end

`ifdef FWID_READER_VERIFY_EN
  assign word = merged;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      q     <= '0;
    end else begin
      if (clear)        shreg <= '0;
      else if (capture) shreg <= merged;
      if (load)         q     <= merged;
    end
  end

endmodule

// File: rtl/fwid_reader.sv
// Reads the 64x1 firmware ID ROM bit by bit into fwid. Optional macro FWID_READER_VERIFY_EN
// reads the ROM twice and flags any difference between the passes on mismatch.
module fwid_reader
  import fwid_reader_pkg::*;
#(
  parameter int ROM_LAT = ROM_LAT_DEFAULT,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              busy,
  output logic [FWID_W-1:0] fwid,
  output logic              fwid_valid,
  output logic              done
`ifdef FWID_READER_VERIFY_EN
  ,
  output logic              mismatch
`endif
);

  localparam logic [1:0]        LAT       = 2'(ROM_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_next;
  logic [1:0]        lat_cnt, cnt_next;
  logic              capture, clear, load, last_bit, final_pass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      lat_cnt    <= '0;
      fwid_valid <= 1'b0;
    end else begin
      state    <= state_next;
      rom_addr <= addr_next;
      lat_cnt  <= cnt_next;
      if (clear)     fwid_valid <= 1'b0;
      else if (load) fwid_valid <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = rom_addr;
    cnt_next   = lat_cnt;
    capture    = 1'b0;
    clear      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADDR;
          addr_next  = '0;
          clear      = 1'b1;
        end
      end
      ADDR: begin
        busy = 1'b1;
        if (ROM_LAT == 0) begin
          capture = 1'b1;
        end else begin
          state_next = WAIT;
          cnt_next   = 2'd1;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAT) capture  = 1'b1;
        else                cnt_next = lat_cnt + 2'd1;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
        addr_next  = '0;
      end
      default: state_next = IDLE;
    endcase

    last_bit = capture && (rom_addr == LAST_ADDR);
    load     = last_bit && final_pass;
    // The final capture edge also loads fwid, so done and fwid_valid rise together with the new word.
    if (capture) begin
      if (load) begin
        state_next = DONE;
      end else begin
        state_next = ADDR;
        addr_next  = rom_addr + 1'b1;
      end
    end
  end

`ifdef FWID_READER_VERIFY_EN
  logic              pass2;
  logic [FWID_W-1:0] first_pass, word;

  assign final_pass = pass2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass2      <= 1'b0;
      first_pass <= '0;
      mismatch   <= 1'b0;
    end else if (clear) begin
      pass2    <= 1'b0;
      mismatch <= 1'b0;
    end else if (last_bit && !pass2) begin
      pass2      <= 1'b1;
      first_pass <= word;
    end else if (load) begin
      mismatch <= (word != first_pass);
    end
  end
`else
  assign final_pass = 1'b1;
`endif

  fwid_shift_capture #(
    .W  (FWID_W),
    .AW (ADDR_W)
  ) u_capture (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .capture (capture),
    .idx     (rom_addr),
    .bit_in  (rom_data),
    .load    (load),
`ifdef FWID_READER_VERIFY_EN
    .word    (word),
`endif
    .q       (fwid)
  );

endmodule

// File: tb/tb_fwid_reader.sv
// Bench for fwid_reader: ROM models with latency 0 and 2, table-driven reads plus abort/ignore corner cases.
module tb_fwid_reader;
  import fwid_reader_pkg::*;

`ifdef FWID_READER_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start2 = 1'b0;
  logic [5:0]  addr0, addr2;
  logic [5:0]  a2_d1 = '0, a2_d2 = '0;
  logic        data0, data2;
  logic        busy0, busy2, valid0, valid2, done0, done2;
  logic [63:0] fwid0, fwid2;
  logic [63:0] rom_init;
  logic        corrupt = 1'b0;
  logic        sel = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    a2_d1 <= addr2;
    a2_d2 <= a2_d1;
  end

  // ROM models: zero-latency combinational, and two-cycle registered address path.
  assign data0 = rom_init[addr0] ^ (corrupt && addr0 == 6'd5);
  assign data2 = rom_init[a2_d2];

`ifdef FWID_READER_VERIFY_EN
  logic mism0, mism2, mism_m;
  assign mism_m = sel ? mism2 : mism0;
`endif

  fwid_reader #(.ROM_LAT(0), .ADDR_W(6)) u0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start0),
    .rom_addr   (addr0),
    .rom_data   (data0),
    .busy       (busy0),
    .fwid       (fwid0),
    .fwid_valid (valid0),
    .done       (done0)
`ifdef FWID_READER_VERIFY_EN
    ,
    .mismatch   (mism0)
`endif
  );

  fwid_reader #(.ROM_LAT(2), .ADDR_W(6)) u2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .rom_addr   (addr2),
    .rom_data   (data2),
    .busy       (busy2),
    .fwid       (fwid2),
    .fwid_valid (valid2),
    .done       (done2)
`ifdef FWID_READER_VERIFY_EN
    ,
    .mismatch   (mism2)
`endif
  );

  logic [5:0]  addr_m;
  logic        busy_m, valid_m, done_m;
  logic [63:0] fwid_m;
  assign addr_m  = sel ? addr2  : addr0;
  assign busy_m  = sel ? busy2  : busy0;
  assign valid_m = sel ? valid2 : valid0;
  assign done_m  = sel ? done2  : done0;
  assign fwid_m  = sel ? fwid2  : fwid0;

  typedef struct {
    logic [63:0] fwid;
    int unsigned lat;
    logic        mism;
    int unsigned t0;
  } exp_t;

  typedef struct {
    logic [63:0] init;
    logic        sel;
    logic [63:0] exp_fwid;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[5];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Pulses start on the selected reader; the sampling edge is cycle 0 of the read.
  task automatic start_read(input logic [63:0] exp_fwid, input logic exp_mism, input bit push);
    exp_t e;
    @(negedge clk);
    if (sel) start2 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
    e.fwid = exp_fwid;
    e.lat  = 64 * ((sel ? 2 : 0) + 1) * PASSES;
    e.mism = exp_mism;
    e.t0   = cyc;
    if (push) sbq.push_back(e);
  endtask

  task automatic wait_done();
    exp_t        e;
    bit          seen;
    int unsigned lim;
    seen = 1'b0;
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected pending read");
      return;
    end
    e   = sbq.pop_front();
    lim = e.lat + 20;
    for (int unsigned i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done_m) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("latency", 64'(cyc - e.t0), 64'(e.lat));
      check("fwid", fwid_m, e.fwid);
      check("fwid_valid", 64'(valid_m), 64'd1);
      check("busy_after", 64'(busy_m), 64'd0);
`ifdef FWID_READER_VERIFY_EN
      check("mismatch", 64'(mism_m), 64'(e.mism));
`endif
      @(negedge clk);
      check("done_width", 64'(done_m), 64'd0);
    end
  endtask

  task automatic count_dones(input int unsigned n, output int unsigned extra);
    extra = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (done0 || done2) extra++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned extra;

    vt[0] = '{64'h1234deadbeef5678, 1'b0, 64'h1234deadbeef5678};
    vt[1] = '{64'h1234deadbeef5678, 1'b1, 64'h1234deadbeef5678};
    vt[2] = '{64'hffffffffffffffff, 1'b0, 64'hffffffffffffffff};
    vt[3] = '{64'h8000000000000001, 1'b0, 64'h8000000000000001};
    vt[4] = '{64'ha5a5c3c30f0f9669, 1'b1, 64'ha5a5c3c30f0f9669};

    rom_init = 64'h1234deadbeef5678;
    repeat (3) @(negedge clk);
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_valid0", 64'(valid0), 64'd0);
    check("rst_fwid0", fwid0, 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    check("rst_fwid2", fwid2, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rom_init = vt[i].init;
      sel      = vt[i].sel;
      start_read(vt[i].exp_fwid, 1'b0, 1'b1);
      check("busy_during", 64'(busy_m), 64'd1);
      check("valid_during", 64'(valid_m), 64'd0);
      check("addr_first", 64'(addr_m), 64'd0);
      wait_done();
    end

    // Latency-2 reader holds each address for three cycles.
    sel      = 1'b1;
    rom_init = 64'h1234deadbeef5678;
    start_read(64'h1234deadbeef5678, 1'b0, 1'b1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("addr_hold", 64'(addr_m), 64'(j / 3));
    end
    wait_done();

    // Start while busy is ignored: one done at cycle 64.
    sel = 1'b0;
    start_read(64'h1234deadbeef5678, 1'b0, 1'b1);
    repeat (29) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done();
    count_dones(80, extra);
    check("no_second_done", 64'(extra), 64'd0);

    // Reset mid-read aborts with no done; next read restarts at address 0.
    start_read(64'h0, 1'b0, 1'b0);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_addr", 64'(addr0), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_done", 64'(done0), 64'd0);
    check("abort_valid", 64'(valid0), 64'd0);
    check("abort_fwid", fwid0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(80, extra);
    check("abort_no_done", 64'(extra), 64'd0);
    rom_init = 64'hcafef00d0badbeef;
    start_read(64'hcafef00d0badbeef, 1'b0, 1'b1);
    wait_done();

    // fwid holds the old word during a new read and updates only at done.
    rom_init = 64'h1234deadbeef5678;
    start_read(64'h1234deadbeef5678, 1'b0, 1'b1);
    wait_done();
    rom_init = 64'h0;
    start_read(64'h0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("hold_fwid", fwid_m, 64'h1234deadbeef5678);
    check("hold_valid", 64'(valid_m), 64'd0);
    wait_done();

`ifdef FWID_READER_VERIFY_EN
    // Second pass sees bit 5 flipped: mismatch raised and fwid takes the second pass.
    rom_init = 64'h1234deadbeef5678;
    start_read(64'h1234deadbeef5658, 1'b1, 1'b1);
    repeat (64) @(negedge clk);
    corrupt = 1'b1;
    wait_done();
    corrupt = 1'b0;
    start_read(64'h1234deadbeef5678, 1'b0, 1'b1);
    check("mismatch_cleared", 64'(mism_m), 64'd0);
    wait_done();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
